// File: rtl/dispatch_steer_if.sv
// Rename -> dispatch -> issue handshake bundle for dispatch_steer.
// master: the dispatch stage. slave: the surrounding rename/issue environment.
interface dispatch_steer_if #(
  parameter int unsigned RENISS_WIDTH = 151
);
  logic                    FREEZE;
  logic                    REN_valid_IN;
  logic [RENISS_WIDTH-1:0] REN_data_IN;
  logic                    REN_stall_OUT;
  logic                    IQ_pushReq_OUT;
  logic [RENISS_WIDTH-1:0] IQ_pushData_OUT;
  logic                    IQ_full_IN;
  logic                    LSQ_pushReq_OUT;
  logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT;
  logic                    LSQ_full_IN;
  logic [31:0]             IQ_pushCnt_OUT;
  logic [31:0]             LSQ_pushCnt_OUT;
  logic [31:0]             blockCnt_OUT;

  modport master (
    input  FREEZE, REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    output REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, LSQ_pushData_OUT,
           IQ_pushCnt_OUT, LSQ_pushCnt_OUT, blockCnt_OUT
  );

  modport slave (
    output FREEZE, REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
    input  REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, LSQ_pushData_OUT,
           IQ_pushCnt_OUT, LSQ_pushCnt_OUT, blockCnt_OUT
  );
endinterface

// File: rtl/dispatch_steer.sv
// Dispatch stage: 2-entry in-order buffer between rename and issue. The head entry is
// steered to the LSQ when either memory bit is set, otherwise to the IQ.
// Optional statistics counters are built only when DISPATCH_STATS_EN is defined;
// otherwise the stats outputs are tied to zero.
module dispatch_steer #(
  parameter int unsigned RENISS_WIDTH = 151,
  parameter int unsigned MEMREAD_BIT  = 39,
  parameter int unsigned MEMWRITE_BIT = 40
) (
  input logic              CLK,
  input logic              RESET,
  dispatch_steer_if.master bus
);

  logic [RENISS_WIDTH-1:0] buf_q [2];
  logic                    head_q;
  logic                    tail_q;
  logic [1:0]              count_q;
  logic [1:0]              count_d;

  logic [RENISS_WIDTH-1:0] head_data;
  logic                    not_empty;
  logic                    is_mem;
  logic                    iq_push;
  logic                    lsq_push;
  logic                    stall;
  logic                    accept;
  logic                    pop;
  logic                    blocked;

  // Head decode, steering and handshake outputs
  always_comb begin
    not_empty = (count_q != 2'd0);
    head_data = buf_q[head_q];
    is_mem    = head_data[MEMREAD_BIT] | head_data[MEMWRITE_BIT];
    iq_push   = not_empty & ~is_mem & ~bus.IQ_full_IN & ~bus.FREEZE;
    lsq_push  = not_empty & is_mem & ~bus.LSQ_full_IN & ~bus.FREEZE;
    stall     = (count_q == 2'd2) | bus.FREEZE;
    accept    = bus.REN_valid_IN & ~stall;
    pop       = iq_push | lsq_push;
    // A full target stalls the head and, by ordering, everything behind it
    blocked   = not_empty & ~bus.FREEZE & (is_mem ? bus.LSQ_full_IN : bus.IQ_full_IN);

    bus.REN_stall_OUT    = stall;
    bus.IQ_pushReq_OUT   = iq_push;
    bus.LSQ_pushReq_OUT  = lsq_push;
    bus.IQ_pushData_OUT  = not_empty ? head_data : '0;
    bus.LSQ_pushData_OUT = not_empty ? head_data : '0;
  end

  // Occupancy next state from accept/pop
  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer storage and pointers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        buf_q[tail_q] <= bus.REN_data_IN;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_d;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] iq_cnt_q;
  logic [31:0] lsq_cnt_q;
  logic [31:0] blk_cnt_q;

  // Statistics counters, wrapping at 2^32
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iq_cnt_q  <= 32'd0;
      lsq_cnt_q <= 32'd0;
      blk_cnt_q <= 32'd0;
    end else begin
      if (iq_push)  iq_cnt_q  <= iq_cnt_q + 32'd1;
      if (lsq_push) lsq_cnt_q <= lsq_cnt_q + 32'd1;
      if (blocked)  blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign bus.IQ_pushCnt_OUT  = iq_cnt_q;
  assign bus.LSQ_pushCnt_OUT = lsq_cnt_q;
  assign bus.blockCnt_OUT    = blk_cnt_q;
`else
  logic unused_blocked;
  assign unused_blocked      = blocked;
  assign bus.IQ_pushCnt_OUT  = 32'd0;
  assign bus.LSQ_pushCnt_OUT = 32'd0;
  assign bus.blockCnt_OUT    = 32'd0;
`endif

endmodule
